led_pattern_engine: RTL and testbench
=====================================

// Module: led_pattern_engine
// PURPOSE
//   Parametrised LED pattern generator: a WIDTH-bit display register driven by an
//   internal prescaler tick. Four run-time selectable modes: binary up, binary down,
//   bounce (one-hot scanner) and Gray count.
//   Sits below the board top level, clocked from the clock-wizard output, driving led[].
//   Replaces the fixed counter + separate impulse pair with one configurable block.
// PARAMETERS
//   WIDTH  16           LED / pattern width in bits; legal range WIDTH >= 2
//   DIV    100_000_000  clk cycles per step tick; legal range DIV >= 1
//   DIV_W  $clog2(DIV)+1  prescaler counter width (derived, do not override)
// PORTS
//   clk    in   1      system clock (single clock domain)
//   rst    in   1      asynchronous, active-high reset
//   en     in   1      run enable; 0 freezes the prescaler and the pattern
//   mode   in   2      00 UP, 01 DOWN, 10 BOUNCE, 11 GRAY (led_mode_t)
//   led    out  WIDTH  pattern output, registered
//   tick   out  1      one-cycle step strobe, registered
//   wrap   out  1      one-cycle strobe marking completion of a pattern period
// BEHAVIOUR
//   Reset (async, rst=1): led=0, tick=0, wrap=0, prescaler=0, bin=0, dir=LEFT, mode_q=UP.
//   Prescaler: on each edge with en=1, cnt counts 0..DIV-1.
//     At cnt==DIV-1: cnt<=0 and tick<=1. Otherwise tick<=0.
//     en=0: cnt holds its value (not cleared) and tick<=0.
//     DIV=1: tick stays high every cycle while en=1.
//   Step: on an edge where tick==1, the pattern advances by one step.
//     led changes one cycle after tick rises.
//     A tick already high advances the pattern even if en has just dropped.
//   Modes (bin is an internal WIDTH-bit counter, mod 2^WIDTH):
//     UP:     led <= led+1. Wrap when all-ones -> 0.
//     DOWN:   led <= led-1. Wrap when 0 -> all-ones.
//     BOUNCE: single lit bit moves 0 -> WIDTH-1, then back -> 0.
//             Direction flips on reaching an end bit. Period 2*WIDTH-2 steps.
//             Wrap on the step that returns to bit 0.
//     GRAY:   bin <= bin+1, led <= next_bin ^ (next_bin>>1). Wrap when bin wraps to 0.
//   wrap is registered together with the led update: high in exactly the cycle led
//   first shows the wrapped value. It is never high outside a step.
//   Mode change: mode is registered into mode_q every cycle.
//     When mode != mode_q, the next edge re-initialises: cnt=0, tick=0, wrap=0, bin=0,
//     dir=LEFT, and led = init value of the new mode.
//     Init values: UP 0, DOWN all-ones, BOUNCE 'b1, GRAY 0.
//     Re-init has priority over a coincident step; that step is discarded.
//   After reset with mode!=UP, re-init occurs on the first edge (treated as a mode change).
//   rst asserted mid-operation clears all state immediately, without a clock edge.
//   No X propagation: every register has a reset value.
// STRUCTURE
//   led_pkg: typedef enum logic [1:0] led_mode_t {MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_GRAY};
//            typedef enum logic dir_t {LEFT, RIGHT}; function bin2gray().
//   Sub-module tick_gen #(DIV): prescaler with en and sync clear inputs, tick output.
//     Reusable elsewhere in the design.
//   Top body: mode_q register, change detect, pattern FSM/datapath, wrap logic.
// TESTING (bench overrides WIDTH=4, DIV=4)
//   1 Reset: rst=1 -> led=0, tick=0, wrap=0 with no clock edge.
//     Release, en=1, mode=UP -> tick every 4th cycle.
//     led 0,1,2..F,0; wrap high exactly with the 16th step (led=0).
//   2 DOWN: mode=01 at reset release -> led=F after 1 edge.
//     Steps E,D..0,F; wrap coincident with F.
//   3 BOUNCE: mode=10 -> led 1,2,4,8,4,2,1.
//     wrap with the return to 1 after 6 steps; sequence repeats.
//   4 GRAY: mode=11 -> led 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap with final 0.
//   5 Enable: drop en when cnt==2 for 10 cycles -> led, cnt frozen, tick=0.
//     Re-raise en -> next tick after exactly 2 more cycles.
//   6 Collisions: change mode UP->BOUNCE in the tick-high cycle -> step discarded, led=1.
//     Assert rst mid-BOUNCE (led=4) between edges -> led=0 asynchronously.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and helpers for the LED pattern engine
package led_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_GRAY   = 2'b11
    } led_mode_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    // Generic 64-bit form; callers truncate to their own width (WIDTH <= 64).
    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/led_pattern_engine_tick_gen.sv
// rtl/led_pattern_engine_tick_gen.sv - prescaler producing a registered one-cycle step tick
module tick_gen #(
    parameter int DIV   = 100_000_000,
    parameter int DIV_W = $clog2(DIV) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    // en low holds the count so a paused run resumes mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - WIDTH-bit LED pattern generator with up/down/bounce/gray modes
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV   = 100_000_000,
    parameter int DIV_W = $clog2(DIV) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  led_mode_t        mode,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);

    led_mode_t        mode_q;
    logic             change;
    logic [WIDTH-1:0] led_q,  nxt_led;
    logic [WIDTH-1:0] bin_q,  nxt_bin;
    logic [WIDTH-1:0] bin_inc;
    dir_t             dir_q,  nxt_dir;
    logic             wrap_q, nxt_wrap;

    assign change = (mode != mode_q);

    tick_gen #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (change),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_UP;
            led_q  <= '0;
            bin_q  <= '0;
            dir_q  <= LEFT;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode;
            led_q  <= nxt_led;
            bin_q  <= nxt_bin;
            dir_q  <= nxt_dir;
            wrap_q <= nxt_wrap;
        end
    end

    // A mode change wins over a coincident tick; that step is dropped.
    always_comb begin
        nxt_led  = led_q;
        nxt_bin  = bin_q;
        nxt_dir  = dir_q;
        nxt_wrap = 1'b0;
        bin_inc  = bin_q + 1'b1;
        if (change) begin
            nxt_bin = '0;
            nxt_dir = LEFT;
            case (mode)
                MODE_DOWN:   nxt_led = '1;
                MODE_BOUNCE: nxt_led = WIDTH'(1);
                default:     nxt_led = '0;
            endcase
        end else if (tick) begin
            case (mode_q)
                MODE_UP: begin
                    nxt_led  = led_q + 1'b1;
                    nxt_wrap = (led_q == '1);
                end
                MODE_DOWN: begin
                    nxt_led  = led_q - 1'b1;
                    nxt_wrap = (led_q == '0);
                end
                MODE_BOUNCE: begin
                    if (dir_q == LEFT) begin
                        nxt_led = led_q << 1;
                        if (led_q[WIDTH-2]) nxt_dir = RIGHT;
                    end else begin
                        nxt_led = led_q >> 1;
                        if (led_q[1]) begin
                            nxt_dir  = LEFT;
                            nxt_wrap = 1'b1;
                        end
                    end
                end
                default: begin
                    nxt_bin  = bin_inc;
                    nxt_led  = WIDTH'(bin2gray(64'(bin_inc)));
                    nxt_wrap = (bin_inc == '0);
                end
            endcase
        end
    end

    always_comb begin
        led  = led_q;
        wrap = wrap_q;
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - self-checking bench for led_pattern_engine (WIDTH=4, DIV=4)
module tb_led_pattern_engine;
    import led_pkg::*;

    typedef struct {
        led_mode_t  mode;
        logic [3:0] led;
        logic       wrap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    led_mode_t  mode = MODE_UP;
    logic [3:0] led;
    logic       tick;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[60];
    vec_t sb_q[$];

    // value+16 marks a step that must raise wrap
    int seq_up[16] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16};
    int seq_dn[16] = '{14,13,12,11,10,9,8,7,6,5,4,3,2,1,0,31};
    int seq_bo[12] = '{2,4,8,4,2,17,2,4,8,4,2,17};
    int seq_gr[16] = '{1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,16};
    int init_exp[4] = '{0,15,1,0};

    led_pattern_engine #(.WIDTH(4), .DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .led  (led),
        .tick (tick),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input int idx, input led_mode_t m, input int v);
        tbl[idx].mode = m;
        tbl[idx].led  = v[3:0];
        tbl[idx].wrap = v[4];
    endtask

    // Async reset between edges, then release with the requested mode.
    task automatic reset_dut(input led_mode_t m);
        @(negedge clk);
        #2;
        rst  = 1'b1;
        mode = m;
        en   = 1'b1;
        #1;
        check("rst_led",  int'(led),  0);
        check("rst_tick", int'(tick), 0);
        check("rst_wrap", int'(wrap), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_steps(input int budget);
        int   cyc;
        int   last;
        logic prev_tick;
        vec_t e;
        cyc       = 0;
        last      = -1;
        prev_tick = 1'b0;
        while (sb_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (prev_tick) begin
                e = sb_q.pop_front();
                check("step_led",  int'(led),  int'(e.led));
                check("step_wrap", int'(wrap), int'(e.wrap));
            end else begin
                check("idle_wrap", int'(wrap), 0);
            end
            if (tick) begin
                if (last >= 0) check("tick_period", cyc - last, 4);
                last = cyc;
            end
            prev_tick = tick;
        end
        if (sb_q.size() > 0) check("step_timeout", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 16; i++) add_vec(i,      MODE_UP,     seq_up[i]);
        for (int i = 0; i < 16; i++) add_vec(16 + i, MODE_DOWN,   seq_dn[i]);
        for (int i = 0; i < 12; i++) add_vec(32 + i, MODE_BOUNCE, seq_bo[i]);
        for (int i = 0; i < 16; i++) add_vec(44 + i, MODE_GRAY,   seq_gr[i]);

        // Mode sweeps: init value one edge after release, then full periods.
        for (int m = 0; m < 4; m++) begin
            reset_dut(led_mode_t'(m));
            check("init_led",  int'(led),  init_exp[m]);
            check("init_wrap", int'(wrap), 0);
            for (int i = 0; i < 60; i++)
                if (tbl[i].mode == led_mode_t'(m)) sb_q.push_back(tbl[i]);
            run_steps(300);
        end

        // Enable freeze with cnt==2, resume, then tick already high when en drops.
        reset_dut(MODE_UP);
        guard = 0;
        while (!tick && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("en_first_tick", int'(tick), 1);
        @(negedge clk);
        check("en_led1", int'(led), 1);
        @(negedge clk);
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("frozen_tick", int'(tick), 0);
            check("frozen_led",  int'(led),  1);
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_tick_early", int'(tick), 0);
        @(negedge clk);
        check("resume_tick", int'(tick), 1);
        en = 1'b0;
        @(negedge clk);
        check("late_step_led",  int'(led),  2);
        check("late_step_tick", int'(tick), 0);
        en = 1'b1;

        // Mode change in the tick-high cycle discards the step.
        reset_dut(MODE_UP);
        guard = 0;
        while (!(tick && led == 4'd3) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("coll_reach", int'(tick && led == 4'd3), 1);
        mode = MODE_BOUNCE;
        @(negedge clk);
        check("coll_led",  int'(led),  1);
        check("coll_tick", int'(tick), 0);
        check("coll_wrap", int'(wrap), 0);

        // Async reset mid-bounce while led shows 4.
        guard = 0;
        while (led != 4'd4 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("bounce_reach4", int'(led), 4);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_led",  int'(led),  0);
        check("mid_rst_tick", int'(tick), 0);
        check("mid_rst_wrap", int'(wrap), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
